// File: rtl/des_subkey_gen_if.sv
// -----------------------------------------------------------------------------
// des_subkey_gen_if
//   Handshake bundle between a DES key-schedule generator and its user.
//
//   Handshake rules (both channels):
//     - Command channel: the user raises start together with key/decrypt.
//       The generator takes them on a clock edge where ready=1 and start=1.
//       start while ready=0 is ignored.
//     - Subkey channel: subkey/round_idx are meaningful only while
//       subkey_valid=1. A transfer happens on an edge where both
//       subkey_valid and subkey_ready are 1. Once subkey_valid rises, it,
//       subkey and round_idx hold until that transfer.
//       subkey_ready while subkey_valid=0 has no effect.
//
//   Signals:
//     start, decrypt, key  user -> gen   launch a schedule (key bit 63 = DES bit 1)
//     subkey_ready         user -> gen   consumer accepts the current subkey
//     ready                gen  -> user  idle, start can be accepted
//     subkey_valid         gen  -> user  subkey/round_idx valid
//     subkey, round_idx    gen  -> user  48-bit subkey, position 0..15 in the sequence
//     done                 gen  -> user  one-cycle pulse after the last transfer
//     key_err              gen  -> user  key parity error flag
//
//   Modports: slave = generator side, master = user side.
// -----------------------------------------------------------------------------
interface des_subkey_gen_if;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        ready;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        done;
  logic        key_err;

  modport slave (
    input  start, decrypt, key, subkey_ready,
    output ready, subkey_valid, subkey, round_idx, done, key_err
  );

  modport master (
    output start, decrypt, key, subkey_ready,
    input  ready, subkey_valid, subkey, round_idx, done, key_err
  );
endinterface

// File: rtl/des_subkey_gen.sv
// -----------------------------------------------------------------------------
// des_subkey_gen
//   Sequential DES key schedule. One accepted start produces the 16 round
//   subkeys, one per handshake, in K1..K16 order (encrypt) or K16..K1 order
//   (decrypt). Decrypt order comes from right-rotating the C/D halves.
//
//   Parameter:
//     PIPE_PC2  0: subkey = PC-2(C,D) combinationally
//               1: PC-2 output registered, one extra cycle per subkey
//   Optional feature (macro PARITY_CHECK_EN):
//     defined   : every key byte must have odd parity at start; on failure
//                 key_err=1 and the run goes straight to FIN (done, no subkeys)
//     undefined : parity bits ignored, key_err tied to 0
//
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     bus            des_subkey_gen_if.slave (start/decrypt/key, ready,
//                    subkey_valid/subkey_ready/subkey/round_idx, done, key_err)
//     o_dbg_state    current FSM state encoding
//     o_dbg_c/_d     current C and D halves
// -----------------------------------------------------------------------------
module des_subkey_gen #(
  parameter int PIPE_PC2 = 0
) (
  input  logic              clk,
  input  logic              rst,
  des_subkey_gen_if.slave   bus,
  output logic [2:0]        o_dbg_state,
  output logic [27:0]       o_dbg_c,
  output logic [27:0]       o_dbg_d
);

  // The shift step is folded into the transfer edge (and into LOAD for the
  // first subkey), so no separate cycle is spent on it.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PC2W = 3'd2,
    S_EMIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // DES bit numbers, 1 = MSB of the source vector.
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  function automatic logic [27:0] f_rot(input logic [27:0] x, input logic left,
                                        input logic two);
    logic [27:0] r;
    if (left) r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    else      r = two ? {x[1:0], x[27:2]}   : {x[0], x[27:1]};
    return r;
  endfunction

  state_t      r_state, w_next;
  logic [27:0] r_c, r_d;
  logic        r_dec;
  logic [3:0]  r_idx;
  logic [55:0] w_pc1;
  logic [47:0] w_pc2, w_subkey;
  logic [4:0]  w_sh_n;
  logic        w_sh_two;
  logic        w_key_bad;
  logic        w_ready, w_valid, w_done;

  assign w_pc1 = f_pc1(bus.key);
  assign w_pc2 = f_pc2({r_c, r_d});

  // Table entry used by the rotation on the current transfer:
  // encrypt needs sh[idx+2] (heading to K(idx+2)), decrypt undoes sh[16-idx].
  assign w_sh_n   = r_dec ? (5'd16 - {1'b0, r_idx}) : ({1'b0, r_idx} + 5'd2);
  assign w_sh_two = !((w_sh_n == 5'd1) || (w_sh_n == 5'd2) ||
                      (w_sh_n == 5'd9) || (w_sh_n == 5'd16));

`ifdef PARITY_CHECK_EN
  logic r_key_err;
  logic [7:0] w_byte_odd;
  always_comb begin
    w_byte_odd = '0;
    for (int b = 0; b < 8; b++) w_byte_odd[b] = ^bus.key[8*b +: 8];
  end
  assign w_key_bad   = ~&w_byte_odd;
  assign bus.key_err = r_key_err;
`else
  assign w_key_bad   = 1'b0;
  assign bus.key_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_valid = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) w_next = w_key_bad ? S_FIN : S_LOAD;
      end
      S_LOAD: w_next = (PIPE_PC2 != 0) ? S_PC2W : S_EMIT;
      S_PC2W: w_next = S_EMIT;
      S_EMIT: begin
        w_valid = 1'b1;
        if (bus.subkey_ready) begin
          if (r_idx == 4'd15)     w_next = S_FIN;
          else if (PIPE_PC2 != 0) w_next = S_PC2W;
          else                    w_next = S_EMIT;
        end
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c   <= '0;
      r_d   <= '0;
      r_dec <= 1'b0;
      r_idx <= '0;
`ifdef PARITY_CHECK_EN
      r_key_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_c   <= w_pc1[55:28];
          r_d   <= w_pc1[27:0];
          r_dec <= bus.decrypt;
          r_idx <= '0;
`ifdef PARITY_CHECK_EN
          r_key_err <= w_key_bad;
`endif
        end
        // Decrypt starts from C0/D0 unrotated because K16 = PC-2(C16,D16)
        // and the 16 shifts sum to a full 28-bit turn.
        S_LOAD: if (!r_dec) begin
          r_c <= f_rot(r_c, 1'b1, 1'b0);
          r_d <= f_rot(r_d, 1'b1, 1'b0);
        end
        S_EMIT: if (bus.subkey_ready && (r_idx != 4'd15)) begin
          r_idx <= r_idx + 4'd1;
          r_c   <= f_rot(r_c, !r_dec, w_sh_two);
          r_d   <= f_rot(r_d, !r_dec, w_sh_two);
        end
        default: ;
      endcase
    end
  end

  if (PIPE_PC2 != 0) begin : g_pipe
    logic [47:0] r_pc2;
    // Captured only in PC2W so the output stays frozen during EMIT stalls.
    always_ff @(posedge clk) begin
      if (rst)                   r_pc2 <= '0;
      else if (r_state == S_PC2W) r_pc2 <= w_pc2;
    end
    assign w_subkey = r_pc2;
  end else begin : g_comb
    assign w_subkey = w_pc2;
  end

  assign bus.ready        = w_ready;
  assign bus.subkey_valid = w_valid;
  assign bus.subkey       = w_subkey;
  assign bus.round_idx    = r_idx;
  assign bus.done         = w_done;
  assign o_dbg_state      = r_state;
  assign o_dbg_c          = r_c;
  assign o_dbg_d          = r_d;

endmodule
